// File: rtl/operand_stack.sv
// LIFO operand stack: DEPTH entries of WIDTH bits, top two entries exposed for the ALU.
// Optional DUP/SWAP support is enabled by defining OPERAND_STACK_DUP_SWAP_EN.
module operand_stack #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 8,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             op_valid_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             err_clr_i,
   output logic [WIDTH-1:0] top_o,
   output logic [WIDTH-1:0] second_o,
   output logic [CW-1:0]    count_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             err_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      OP_NOP      = 3'b000,
      OP_PUSH     = 3'b001,
      OP_POP      = 3'b010,
      OP_POP2PUSH = 3'b011,
      OP_DUP      = 3'b100,
      OP_SWAP     = 3'b101,
      OP_CLEAR    = 3'b110,
      OP_RSVD     = 3'b111
   } opCode_e;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic             err_q, err_d;

   logic             legal;
   logic             wr0En, wr1En;
   logic [AW-1:0]    wr0Idx, wr1Idx;
   logic [WIDTH-1:0] wr0Data, wr1Data;

   logic [CW-1:0]    topPtr, secondPtr;
   logic [WIDTH-1:0] topRaw, secondRaw;
   logic             isEmpty, isFull, hasTwo;

   assign topPtr    = count_q - CW'(1);
   assign secondPtr = count_q - CW'(2);
   assign topRaw    = mem_q[topPtr[AW-1:0]];
   assign secondRaw = mem_q[secondPtr[AW-1:0]];
   assign isEmpty   = (count_q == '0);
   assign isFull    = (count_q == CW'(DEPTH));
   assign hasTwo    = (count_q >= CW'(2));

   // Decode the op into a legality flag, the new count and up to two storage writes.
   always_comb begin
      legal   = 1'b0;
      count_d = count_q;
      wr0En   = 1'b0;
      wr0Idx  = count_q[AW-1:0];
      wr0Data = push_data_i;
      wr1En   = 1'b0;
      wr1Idx  = secondPtr[AW-1:0];
      wr1Data = topRaw;
      unique case (opCode_e'(op_i))
         OP_NOP:   legal = 1'b1;
         OP_PUSH: begin
            legal   = !isFull;
            count_d = count_q + CW'(1);
            wr0En   = 1'b1;
         end
         OP_POP: begin
            legal   = !isEmpty;
            count_d = count_q - CW'(1);
         end
         OP_POP2PUSH: begin
            legal   = hasTwo;
            count_d = count_q - CW'(1);
            wr0En   = 1'b1;
            wr0Idx  = secondPtr[AW-1:0];
         end
`ifdef OPERAND_STACK_DUP_SWAP_EN
         OP_DUP: begin
            legal   = !isEmpty && !isFull;
            count_d = count_q + CW'(1);
            wr0En   = 1'b1;
            wr0Data = topRaw;
         end
         OP_SWAP: begin
            legal   = hasTwo;
            wr0En   = 1'b1;
            wr0Idx  = topPtr[AW-1:0];
            wr0Data = secondRaw;
            wr1En   = 1'b1;
         end
`else
         OP_DUP:   legal = 1'b0;
         OP_SWAP:  legal = 1'b0;
`endif
         OP_CLEAR: begin
            legal   = 1'b1;
            count_d = '0;
         end
         OP_RSVD:  legal = 1'b0;
         default:  legal = 1'b0;
      endcase
   end

   // Set wins over clear so a coincident illegal op is never lost.
   always_comb begin
      err_d = err_q;
      if (op_valid_i && !legal) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         err_q <= err_d;
         if (op_valid_i && legal) begin
            count_q <= count_d;
            if (wr0En) begin
               mem_q[wr0Idx] <= wr0Data;
            end
            if (wr1En) begin
               mem_q[wr1Idx] <= wr1Data;
            end
         end
      end
   end

   assign top_o    = isEmpty ? '0 : topRaw;
   assign second_o = hasTwo ? secondRaw : '0;
   assign count_o  = count_q;
   assign empty_o  = isEmpty;
   assign full_o   = isFull;
   assign err_o    = err_q;

endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: directed sequences plus random ops against a queue model.
module tb_operand_stack;

   localparam int WIDTH = 5;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, P2P = 3'd3,
                          DUP = 3'd4, SWAP = 3'd5, CLR = 3'd6, RSV = 3'd7;

   logic             clk = 1'b0;
   logic             rst;
   logic             opValid;
   logic [2:0]       op;
   logic [WIDTH-1:0] pushData;
   logic             errClr;
   logic [WIDTH-1:0] top, second;
   logic [CW-1:0]    count;
   logic             empty, full, err;

   int vectors = 0;
   int miscompares = 0;

   int modelStack[$];
   bit modelErr;

   operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .op_valid_i  (opValid),
      .op_i        (op),
      .push_data_i (pushData),
      .err_clr_i   (errClr),
      .top_o       (top),
      .second_o    (second),
      .count_o     (count),
      .empty_o     (empty),
      .full_o      (full),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   // Reference behaviour expressed directly as stack operations on a queue.
   task automatic modelStep(input bit r, input bit v, input logic [2:0] o,
                            input int d, input bit c);
      bit ok;
      int n, t, s;
      n = modelStack.size();
      if (r) begin
         modelStack.delete();
         modelErr = 1'b0;
         return;
      end
      ok = 1'b1;
      if (v) begin
         case (o)
            NOP:  ok = 1'b1;
            PUSH: if (n < DEPTH) modelStack.push_back(d); else ok = 1'b0;
            POP:  if (n > 0) void'(modelStack.pop_back()); else ok = 1'b0;
            P2P: begin
               if (n >= 2) begin
                  void'(modelStack.pop_back());
                  void'(modelStack.pop_back());
                  modelStack.push_back(d);
               end else ok = 1'b0;
            end
`ifdef OPERAND_STACK_DUP_SWAP_EN
            DUP:  if (n >= 1 && n < DEPTH) modelStack.push_back(modelStack[n-1]); else ok = 1'b0;
            SWAP: begin
               if (n >= 2) begin
                  t = modelStack.pop_back();
                  s = modelStack.pop_back();
                  modelStack.push_back(t);
                  modelStack.push_back(s);
               end else ok = 1'b0;
            end
`endif
            CLR:  modelStack.delete();
            default: ok = 1'b0;
         endcase
      end
      if (v && !ok) modelErr = 1'b1;
      else if (c) modelErr = 1'b0;
   endtask

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      int n;
      n = modelStack.size();
      checkVal("count",  32'(count),  32'(n));
      checkVal("top",    32'(top),    32'(n == 0 ? 0 : modelStack[n-1]));
      checkVal("second", 32'(second), 32'(n < 2 ? 0 : modelStack[n-2]));
      checkVal("empty",  32'(empty),  32'(n == 0));
      checkVal("full",   32'(full),   32'(n == DEPTH));
      checkVal("err",    32'(err),    32'(modelErr));
   endtask

   // Drive one cycle of inputs, advance the model, then check outputs after the edge.
   task automatic applyStimulus(input bit r, input bit v, input logic [2:0] o,
                                input int d, input bit c);
      @(negedge clk);
      rst      = r;
      opValid  = v;
      op       = o;
      pushData = WIDTH'(d);
      errClr   = c;
      @(posedge clk);
      modelStep(r, v, o, d & ((1 << WIDTH) - 1), c);
      #1;
      checkOutput();
   endtask

   initial begin
      rst = 1'b1; opValid = 1'b0; op = NOP; pushData = '0; errClr = 1'b0;
      modelErr = 1'b0;

      applyStimulus(1, 0, NOP, 0, 0);
      checkVal("reset_empty", 32'(empty), 32'd1);

      applyStimulus(0, 1, PUSH, 3, 0);
      applyStimulus(0, 1, PUSH, 7, 0);
      applyStimulus(0, 1, PUSH, 12, 0);
      applyStimulus(0, 1, PUSH, 31, 0);
      checkVal("fill_top", 32'(top), 32'd31);
      checkVal("fill_second", 32'(second), 32'd12);
      applyStimulus(0, 1, PUSH, 9, 0);
      checkVal("overflow_err", 32'(err), 32'd1);
      checkVal("overflow_top", 32'(top), 32'd31);

      applyStimulus(1, 0, NOP, 0, 0);
      applyStimulus(0, 1, POP, 0, 0);
      checkVal("underflow_err", 32'(err), 32'd1);
      applyStimulus(0, 0, NOP, 0, 1);
      checkVal("errclr", 32'(err), 32'd0);
      applyStimulus(0, 1, RSV, 0, 1);
      checkVal("set_wins", 32'(err), 32'd1);
      applyStimulus(0, 0, NOP, 0, 1);

      applyStimulus(0, 1, PUSH, 6, 0);
      applyStimulus(0, 1, PUSH, 4, 0);
      applyStimulus(0, 1, P2P, 10, 0);
      checkVal("p2p_top", 32'(top), 32'd10);
      checkVal("p2p_count", 32'(count), 32'd1);
      applyStimulus(0, 1, P2P, 21, 0);
      checkVal("p2p_illegal_top", 32'(top), 32'd10);

      applyStimulus(1, 0, NOP, 0, 0);
      applyStimulus(0, 1, PUSH, 2, 0);
      applyStimulus(0, 1, PUSH, 9, 0);
      applyStimulus(0, 1, SWAP, 0, 0);
      applyStimulus(0, 1, DUP, 0, 0);
      applyStimulus(0, 1, DUP, 0, 0);
      applyStimulus(0, 1, DUP, 0, 0);

      applyStimulus(1, 0, NOP, 0, 0);
      applyStimulus(0, 1, PUSH, 5, 0);
      applyStimulus(0, 1, PUSH, 8, 0);
      applyStimulus(0, 1, CLR, 0, 0);
      checkVal("clear_top", 32'(top), 32'd0);
      applyStimulus(0, 0, PUSH, 13, 0);
      checkVal("idle_count", 32'(count), 32'd0);

      applyStimulus(0, 1, PUSH, 1, 0);
      applyStimulus(0, 1, PUSH, 2, 0);
      applyStimulus(0, 1, PUSH, 3, 0);
      applyStimulus(0, 1, RSV, 0, 0);
      applyStimulus(1, 1, PUSH, 17, 0);
      checkVal("rst_over_push", 32'(count), 32'd0);

      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 99) == 0,
                       $urandom_range(0, 9) != 0,
                       3'($urandom_range(0, 7)),
                       int'($urandom_range(0, 31)),
                       $urandom_range(0, 7) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
